// File: rtl/aes_ark_pkg.sv
// rtl/aes_ark_pkg.sv - shared types, defaults and key-slot helper for the AddRoundKey engine
package aes_ark_pkg;

  localparam int AES_DATA_W    = 128;
  localparam int AES128_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OUT     = 2'd1,
    WAIT_FB = 2'd2
  } ark_state_e;

  // Decryption consumes the key schedule from the last slot back to slot 0.
  function automatic int unsigned key_slot(input logic mode, input int unsigned rnd,
                                           input int unsigned num_rounds);
    return mode ? (num_rounds - rnd) : rnd;
  endfunction

endpackage

// File: rtl/round_key_file.sv
// rtl/round_key_file.sv - round-key register file, one sync write port, one comb read port
module round_key_file
  import aes_ark_pkg::*;
#(
  parameter int DATA_W     = AES_DATA_W,
  parameter int NUM_ROUNDS = AES128_ROUNDS,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              wr_en,
  input  logic [CNT_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [CNT_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] keys_q [NUM_ROUNDS+1];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) keys_q[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        if (wr_idx == CNT_W'(i)) keys_q[i] <= wr_data;
      end
    end
  end

  // Out-of-range indices read as zero rather than aliasing onto a stored slot.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      if (rd_idx == CNT_W'(i)) rd_data = keys_q[i];
    end
  end

endmodule

// File: rtl/aes_round_key_engine.sv
// rtl/aes_round_key_engine.sv - sequential AddRoundKey engine, forward or reversed key order
module aes_round_key_engine
  import aes_ark_pkg::*;
#(
  parameter int DATA_W     = AES_DATA_W,
  parameter int NUM_ROUNDS = AES128_ROUNDS,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              key_wr_en,
  input  logic [CNT_W-1:0]  key_wr_idx,
  input  logic [DATA_W-1:0] key_wr_data,
  output logic              key_wr_drop,
  input  logic              decrypt,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fb_valid,
  output logic              fb_ready,
  input  logic [DATA_W-1:0] fb_data,
  output logic              ark_valid,
  input  logic              ark_ready,
  output logic [DATA_W-1:0] ark_data,
  output logic [CNT_W-1:0]  ark_round,
  output logic              ark_last,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(NUM_ROUNDS);

  ark_state_e        state_q, state_d;
  logic [CNT_W-1:0]  rnd_q, rnd_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] ark_data_q, ark_data_d;
  logic [CNT_W-1:0]  ark_round_q, ark_round_d;
  logic              ark_last_q, ark_last_d;
  logic              ark_valid_q, ark_valid_d;
  logic              key_wr_drop_q, key_wr_drop_d;

  logic [CNT_W-1:0]  sel;
  logic [DATA_W-1:0] key_rd;
  logic              key_wr_ok;
  logic              start_fire, fb_fire, ark_fire, at_last;

  assign start_fire = start_valid && (state_q == IDLE);
  assign fb_fire    = fb_valid && (state_q == WAIT_FB);
  assign ark_fire   = ark_ready && (state_q == OUT);
  assign at_last    = (rnd_q == LAST_RND);
  assign key_wr_ok  = key_wr_en && (state_q == IDLE) && (key_wr_idx <= LAST_RND);

  round_key_file #(
    .DATA_W     (DATA_W),
    .NUM_ROUNDS (NUM_ROUNDS),
    .CNT_W      (CNT_W)
  ) u_keys (
    .clk     (clk),
    .n_rst   (n_rst),
    .wr_en   (key_wr_ok),
    .wr_idx  (key_wr_idx),
    .wr_data (key_wr_data),
    .rd_idx  (sel),
    .rd_data (key_rd)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_valid) state_d = OUT;
        OUT:     if (ark_ready)   state_d = at_last ? IDLE : WAIT_FB;
        WAIT_FB: if (fb_valid)    state_d = OUT;
        default: state_d = IDLE;
      endcase
    end
  end

  // In IDLE the mode register is stale, so the start lookup uses the live decrypt input.
  always_comb begin
    start_ready = (state_q == IDLE);
    fb_ready    = (state_q == WAIT_FB);
    busy        = (state_q != IDLE);
    if (state_q == IDLE) sel = CNT_W'(key_slot(decrypt, 32'd0, NUM_ROUNDS));
    else                 sel = CNT_W'(key_slot(mode_q, 32'(rnd_q), NUM_ROUNDS));
  end

  always_comb begin
    rnd_d         = rnd_q;
    mode_d        = mode_q;
    ark_data_d    = ark_data_q;
    ark_round_d   = ark_round_q;
    ark_last_d    = ark_last_q;
    ark_valid_d   = ark_valid_q;
    key_wr_drop_d = key_wr_en && !key_wr_ok;
    if (clear) begin
      rnd_d       = '0;
      ark_valid_d = 1'b0;
      ark_last_d  = 1'b0;
    end else if (start_fire) begin
      mode_d      = decrypt;
      rnd_d       = '0;
      ark_data_d  = data_in ^ key_rd;
      ark_round_d = '0;
      ark_last_d  = (LAST_RND == '0);
      ark_valid_d = 1'b1;
    end else if (ark_fire) begin
      ark_valid_d = 1'b0;
      ark_last_d  = 1'b0;
      rnd_d       = at_last ? '0 : rnd_q + 1'b1;
    end else if (fb_fire) begin
      ark_data_d  = fb_data ^ key_rd;
      ark_round_d = rnd_q;
      ark_last_d  = at_last;
      ark_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rnd_q         <= '0;
      mode_q        <= 1'b0;
      ark_data_q    <= '0;
      ark_round_q   <= '0;
      ark_last_q    <= 1'b0;
      ark_valid_q   <= 1'b0;
      key_wr_drop_q <= 1'b0;
    end else begin
      rnd_q         <= rnd_d;
      mode_q        <= mode_d;
      ark_data_q    <= ark_data_d;
      ark_round_q   <= ark_round_d;
      ark_last_q    <= ark_last_d;
      ark_valid_q   <= ark_valid_d;
      key_wr_drop_q <= key_wr_drop_d;
    end
  end

  assign ark_valid   = ark_valid_q;
  assign ark_data    = ark_data_q;
  assign ark_round   = ark_round_q;
  assign ark_last    = ark_last_q;
  assign key_wr_drop = key_wr_drop_q;

endmodule

// File: tb/tb_aes_round_key_engine.sv
// tb/tb_aes_round_key_engine.sv - self-checking bench for aes_round_key_engine
module tb_aes_round_key_engine;

  localparam int NR = 10;

  logic         clk, n_rst, clear;
  logic         key_wr_en, key_wr_drop;
  logic [3:0]   key_wr_idx;
  logic [127:0] key_wr_data;
  logic         decrypt, start_valid, start_ready;
  logic [127:0] data_in, fb_data, ark_data;
  logic         fb_valid, fb_ready, ark_valid, ark_ready, ark_last, busy;
  logic [3:0]   ark_round;

  logic [127:0] mkey [NR+1];
  int n_cmp = 0;
  int n_bad = 0;

  aes_round_key_engine dut (
    .clk(clk), .n_rst(n_rst), .clear(clear),
    .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
    .key_wr_drop(key_wr_drop), .decrypt(decrypt),
    .start_valid(start_valid), .start_ready(start_ready), .data_in(data_in),
    .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_data(fb_data),
    .ark_valid(ark_valid), .ark_ready(ark_ready), .ark_data(ark_data),
    .ark_round(ark_round), .ark_last(ark_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic write_key(input int idx, input logic [127:0] val, input bit exp_drop);
    key_wr_en = 1'b1; key_wr_idx = 4'(idx); key_wr_data = val;
    tick();
    key_wr_en = 1'b0;
    n_cmp++;
    if (key_wr_drop !== exp_drop) begin
      n_bad++;
      $display("FAIL key_wr_drop idx=%0d got=%b want=%b", idx, key_wr_drop, exp_drop);
    end
    if (!exp_drop) mkey[idx] = val;
  endtask

  // Drives one block; stall_rnd holds ark_ready low 5 cycles, abort_rnd clears in that round.
  task automatic run_block(input logic [127:0] din, input logic dec, input bit zero_fb,
                           input int stall_rnd, input int abort_rnd, input bit gaps);
    logic [127:0] cur, exp, held;
    int w;
    w = 0;
    while (start_ready !== 1'b1 && w < 50) begin tick(); w++; end
    n_cmp++;
    if (start_ready !== 1'b1) begin n_bad++; $display("FAIL start_ready_timeout got=%b want=1", start_ready); end
    start_valid = 1'b1; data_in = din; decrypt = dec;
    tick();
    start_valid = 1'b0; data_in = rnd128(); decrypt = 1'($urandom());
    cur = din;
    for (int r = 0; r <= NR; r++) begin
      exp = cur ^ mkey[dec ? NR - r : r];
      n_cmp++;
      if (ark_valid !== 1'b1 || ark_data !== exp || ark_round !== 4'(r) || ark_last !== (r == NR)) begin
        n_bad++;
        $display("FAIL ark_out r=%0d got v=%b d=%h rd=%0d l=%b want v=1 d=%h rd=%0d l=%b",
                 r, ark_valid, ark_data, ark_round, ark_last, exp, r, (r == NR));
      end
      if (r == abort_rnd) begin
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++;
        if (ark_valid !== 1'b0 || ark_last !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0 || ark_data !== exp) begin
          n_bad++;
          $display("FAIL clear_state got v=%b l=%b sr=%b busy=%b d=%h want v=0 l=0 sr=1 busy=0 d=%h",
                   ark_valid, ark_last, start_ready, busy, ark_data, exp);
        end
        return;
      end
      if (r == stall_rnd) begin
        held = ark_data;
        for (int s = 0; s < 5; s++) begin
          fb_valid = 1'b1; fb_data = rnd128();
          tick();
          fb_valid = 1'b0;
          n_cmp++;
          if (ark_valid !== 1'b1 || ark_data !== held || ark_round !== 4'(r) || fb_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL stall s=%0d got v=%b d=%h rd=%0d fbr=%b want v=1 d=%h rd=%0d fbr=0",
                     s, ark_valid, ark_data, ark_round, fb_ready, held, r);
          end
        end
      end
      ark_ready = 1'b1;
      tick();
      ark_ready = 1'b0;
      if (r == NR) break;
      if (gaps) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      end
      n_cmp++;
      if (fb_ready !== 1'b1 || ark_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL wait_fb r=%0d got fbr=%b v=%b want fbr=1 v=0", r, fb_ready, ark_valid);
      end
      cur = zero_fb ? '0 : rnd128();
      fb_valid = 1'b1; fb_data = cur;
      tick();
      fb_valid = 1'b0;
    end
    n_cmp++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || ark_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL block_end got sr=%b busy=%b v=%b want sr=1 busy=0 v=0", start_ready, busy, ark_valid);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    #12;
    n_cmp++;
    if (start_ready !== 1'b1 || fb_ready !== 1'b0 || busy !== 1'b0 || ark_valid !== 1'b0 ||
        ark_last !== 1'b0 || ark_round !== 4'd0 || ark_data !== 128'd0 || key_wr_drop !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state got sr=%b fbr=%b busy=%b v=%b l=%b rd=%0d d=%h drop=%b want sr=1 others 0",
               start_ready, fb_ready, busy, ark_valid, ark_last, ark_round, ark_data, key_wr_drop);
    end
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    for (int i = 0; i <= NR; i++) mkey[i] = '0;
    run_block(rnd128(), 1'b0, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_round0();
    for (int i = 0; i <= NR; i++) write_key(i, rnd128(), 1'b0);
    write_key(0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
    start_valid = 1'b1; data_in = 128'h3243f6a8885a308d313198a2e0370734; decrypt = 1'b0;
    tick();
    start_valid = 1'b0;
    n_cmp++;
    if (ark_valid !== 1'b1 || ark_data !== 128'h193de3bea0f4e22b9ac68d2ae9f84808 ||
        ark_round !== 4'd0 || ark_last !== 1'b0) begin
      n_bad++;
      $display("FAIL round0_vector got v=%b d=%h rd=%0d l=%b want v=1 d=193de3bea0f4e22b9ac68d2ae9f84808 rd=0 l=0",
               ark_valid, ark_data, ark_round, ark_last);
    end
    clear = 1'b1; tick(); clear = 1'b0;
    run_block(rnd128(), 1'b0, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_decrypt();
    for (int i = 0; i <= NR; i++) write_key(i, {16{8'(i)}}, 1'b0);
    run_block(rnd128(), 1'b1, 1'b1, -1, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    run_block(rnd128(), 1'($urandom()), 1'b0, 3, -1, 1'b0);
  endtask

  task automatic test_key_protect();
    start_valid = 1'b1; data_in = rnd128(); decrypt = 1'b0;
    tick();
    start_valid = 1'b0;
    write_key(3, rnd128(), 1'b1);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_during_block got=%b want=1", busy); end
    tick();
    n_cmp++;
    if (key_wr_drop !== 1'b0) begin n_bad++; $display("FAIL drop_pulse_width got=%b want=0", key_wr_drop); end
    clear = 1'b1; tick(); clear = 1'b0;
    write_key(11, rnd128(), 1'b1);
    write_key(15, rnd128(), 1'b1);
    write_key(10, rnd128(), 1'b0);
    run_block(rnd128(), 1'b0, 1'b0, -1, -1, 1'b0);
    run_block(rnd128(), 1'b1, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_same_cycle();
    logic [127:0] din, nk;
    din = rnd128(); nk = rnd128();
    start_valid = 1'b1; data_in = din; decrypt = 1'b0;
    key_wr_en = 1'b1; key_wr_idx = 4'd0; key_wr_data = nk;
    tick();
    start_valid = 1'b0; key_wr_en = 1'b0;
    n_cmp++;
    if (ark_data !== (din ^ mkey[0]) || key_wr_drop !== 1'b0) begin
      n_bad++;
      $display("FAIL same_cycle_old_key got d=%h drop=%b want d=%h drop=0", ark_data, key_wr_drop, din ^ mkey[0]);
    end
    mkey[0] = nk;
    clear = 1'b1; tick(); clear = 1'b0;
    run_block(rnd128(), 1'b0, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_clear();
    run_block(rnd128(), 1'($urandom()), 1'b0, -1, 5, 1'b0);
    run_block(rnd128(), 1'($urandom()), 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 8; b++) begin
      if ($urandom_range(0, 2) == 0) write_key(int'($urandom_range(0, NR)), rnd128(), 1'b0);
      run_block(rnd128(), 1'($urandom()), 1'b0, -1, -1, 1'($urandom()));
    end
  endtask

  task automatic test_reset_mid_block();
    start_valid = 1'b1; data_in = rnd128(); decrypt = 1'b1;
    tick();
    start_valid = 1'b0;
    ark_ready = 1'b1; tick(); ark_ready = 1'b0;
    fb_valid = 1'b1; fb_data = rnd128(); tick(); fb_valid = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    n_cmp++;
    if (ark_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0 || fb_ready !== 1'b0 || ark_data !== 128'd0) begin
      n_bad++;
      $display("FAIL async_reset got v=%b sr=%b busy=%b fbr=%b d=%h want v=0 sr=1 busy=0 fbr=0 d=0",
               ark_valid, start_ready, busy, fb_ready, ark_data);
    end
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    for (int i = 0; i <= NR; i++) mkey[i] = '0;
    run_block(rnd128(), 1'b0, 1'b0, -1, -1, 1'b0);
    run_block(rnd128(), 1'b1, 1'b0, -1, -1, 1'b0);
  endtask

  initial begin
    n_rst = 1'b0; clear = 1'b0;
    key_wr_en = 1'b0; key_wr_idx = '0; key_wr_data = '0;
    decrypt = 1'b0; start_valid = 1'b0; data_in = '0;
    fb_valid = 1'b0; fb_data = '0; ark_ready = 1'b0;
    test_reset();
    test_round0();
    test_decrypt();
    test_backpressure();
    test_key_protect();
    test_same_cycle();
    test_clear();
    test_back_to_back();
    test_reset_mid_block();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
